// File: rtl/mxm_rd_seq_pkg.sv
// Shared types for the MXM read sequencer.
// Holds the FSM state encoding and the default counter width.
package mxm_rd_seq_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mxm_rd_seq_if.sv
// Instruction, MXM read port and status bundle
// between the decoder, the sequencer and the MXM.
interface mxm_rd_seq_if #(
  parameter int W = 16
) ();

  logic         start;
  logic [W-1:0] vec_size;
  logic [W-1:0] n_rnds;
  logic [W-1:0] n_vecs;
  logic         stall;
  logic         mxm_empty;
  logic         mxm_almost_empty;
  logic         rd_en;
  logic         rd_last_rnd;
  logic [W-1:0] vec_size_o;
  logic [W-1:0] vec_size_minus_1_o;
  logic         busy;
  logic         done;

  modport slave (
    input  start, vec_size, n_rnds, n_vecs,
    input  stall, mxm_empty, mxm_almost_empty,
    output rd_en, rd_last_rnd,
    output vec_size_o, vec_size_minus_1_o,
    output busy, done
  );

  modport master (
    output start, vec_size, n_rnds, n_vecs,
    output stall, mxm_empty, mxm_almost_empty,
    input  rd_en, rd_last_rnd,
    input  vec_size_o, vec_size_minus_1_o,
    input  busy, done
  );

endinterface

// File: rtl/mxm_nest_cnt.sv
// Three-level nested counter (element / round / vector),
// shared by the conv and pool read sequencers.
module mxm_nest_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_ele_m1,
  input  logic [CNT_W-1:0] i_rnd_m1,
  input  logic [CNT_W-1:0] i_vec_m1,
  output logic             o_ele_wrap,
  output logic             o_rnd_last,
  output logic             o_all_last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_ele;
  logic [CNT_W-1:0] r_rnd;
  logic [CNT_W-1:0] r_vec;

  assign o_ele_wrap = (r_ele == i_ele_m1);
  assign o_rnd_last = (r_rnd == i_rnd_m1);
  assign o_all_last = o_ele_wrap && o_rnd_last
                   && (r_vec == i_vec_m1);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ele <= '0;
      r_rnd <= '0;
      r_vec <= '0;
    end else if (i_inc) begin
      if (o_ele_wrap) begin
        r_ele <= '0;
        if (o_rnd_last) begin
          r_rnd <= '0;
          r_vec <= r_vec + ONE;
        end else begin
          r_rnd <= r_rnd + ONE;
        end
      end else begin
        r_ele <= r_ele + ONE;
      end
    end
  end

endmodule

// File: rtl/mxm_rd_seq.sv
// MXM read sequencer: turns one size/round/vector instruction
// into throttled read strobes plus the last-round flag.
module mxm_rd_seq #(
  parameter int CNT_W = mxm_rd_seq_pkg::CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mxm_rd_seq_if.slave bus
);

  import mxm_rd_seq_pkg::*;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_vsz;
  logic [CNT_W-1:0] r_vsz_m1;
  logic [CNT_W-1:0] r_rnd_m1;
  logic [CNT_W-1:0] r_vec_m1;
  logic             r_rd_en_q;
  logic             r_busy;
  logic             r_done;

  logic w_rd_en;
  logic w_clr;
  logic w_ele_wrap;
  logic w_rnd_last;
  logic w_all_last;

  // Flags lag one cycle: a read last cycle may have
  // taken the only element almost_empty reported.
  assign w_rd_en = !rst
                && (r_state == S_RUN)
                && !bus.stall
                && !bus.mxm_empty
                && !(bus.mxm_almost_empty && r_rd_en_q);

  assign w_clr = (r_state == S_IDLE) && bus.start;

  mxm_nest_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_inc      (w_rd_en),
    .i_ele_m1   (r_vsz_m1),
    .i_rnd_m1   (r_rnd_m1),
    .i_vec_m1   (r_vec_m1),
    .o_ele_wrap (w_ele_wrap),
    .o_rnd_last (w_rnd_last),
    .o_all_last (w_all_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vsz     <= '0;
      r_vsz_m1  <= '0;
      r_rnd_m1  <= '0;
      r_vec_m1  <= '0;
      r_rd_en_q <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en_q <= w_rd_en;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_vsz    <= bus.vec_size;
            r_vsz_m1 <= bus.vec_size - ONE;
            r_rnd_m1 <= bus.n_rnds - ONE;
            r_vec_m1 <= bus.n_vecs - ONE;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_rd_en && w_ele_wrap && w_all_last) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en              = w_rd_en;
  assign bus.rd_last_rnd        = (r_state == S_RUN) && w_rnd_last;
  assign bus.vec_size_o         = r_vsz;
  assign bus.vec_size_minus_1_o = r_vsz_m1;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;

endmodule
